// File: rtl/mutex_pkg.sv
// mutex_pkg: shared definitions for the mutex arbiter slice.
//   state_t    : arbiter FSM states (IDLE, OWNED, REVOKED)
//   MODE_FIXED : lowest requester index always wins
//   MODE_RR    : round-robin, priority rotates past the last winner
//   idx_w(n)   : width of an encoded requester index (at least 1 bit)
package mutex_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    REVOKED = 2'd2
  } state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mutex_arbiter_if.sv
// mutex_arbiter_if: request/grant bundle between N requesters and the arbiter.
//   Request    : level request per requester, held for the whole ownership
//   Grant      : one-hot or zero ownership vector
//   GrantIndex : encoded index of the set Grant bit, 0 when idle
//   Busy       : some requester owns the resource
//   Revoke     : one-cycle pulse when the tenure limit removed a grant
// Modports: master = requester side, slave = arbiter side.
interface mutex_arbiter_if #(
  parameter int N = 4
) ();
  import mutex_pkg::*;

  logic [N-1:0]          Request;
  logic [N-1:0]          Grant;
  logic [idx_w(N)-1:0]   GrantIndex;
  logic                  Busy;
  logic                  Revoke;

  modport master (output Request, input Grant, GrantIndex, Busy, Revoke);
  modport slave  (input Request, output Grant, GrantIndex, Busy, Revoke);

endinterface

// File: rtl/mutex_pick.sv
// mutex_pick: combinational rotate-and-priority-encode.
//   req    : request vector
//   mask   : requesters excluded from this arbitration
//   ptr    : index holding highest priority; search wraps modulo N
//   onehot : winner as a one-hot vector
//   idx    : winner index
//   valid  : at least one eligible requester
module mutex_pick import mutex_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        mask,
  input  logic [idx_w(N)-1:0] ptr,
  output logic [N-1:0]        onehot,
  output logic [idx_w(N)-1:0] idx,
  output logic                valid
);

  logic [N-1:0] elig;
  logic         found_hi, found_lo;
  int           hi_i, lo_i, win;

  assign elig = req & ~mask;

  // Scan downwards so the lowest eligible index in each half survives: the
  // upper half (at or above ptr) beats the wrapped lower half.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_i     = 0;
    lo_i     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        if (i >= int'(ptr)) begin
          found_hi = 1'b1;
          hi_i     = i;
        end else begin
          found_lo = 1'b1;
          lo_i     = i;
        end
      end
    end
    win    = found_hi ? hi_i : lo_i;
    valid  = found_hi | found_lo;
    onehot = valid ? (N'(1) << win) : '0;
    idx    = valid ? idx_w(N)'(win) : '0;
  end

endmodule

// File: rtl/mutex_arbiter.sv
// mutex_arbiter: grants one shared resource to one of N requesters.
//   Parameters: N requesters, MODE (MODE_FIXED / MODE_RR), MAX_HOLD tenure
//   limit in cycles while others wait (0 = unlimited).
//   Clk    : rising-edge clock
//   nReset : asynchronous active-low reset
//   bus    : slave side of mutex_arbiter_if (Request in; Grant, GrantIndex,
//            Busy, Revoke out, all registered)
// Break-before-make: every change of owner passes through a Grant = 0 cycle.
module mutex_arbiter import mutex_pkg::*; #(
  parameter int N        = 4,
  parameter int MODE     = MODE_FIXED,
  parameter int MAX_HOLD = 0
) (
  input  logic           nReset,
  input  logic           Clk,
  mutex_arbiter_if.slave bus
);

  localparam int IW = idx_w(N);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  state_t          state, state_nxt;
  logic [N-1:0]    grant, grant_nxt;
  logic [N-1:0]    rev_oh, rev_nxt;
  logic [N-1:0]    mask, win_oh;
  logic [IW-1:0]   idx, idx_nxt;
  logic [IW-1:0]   ptr, ptr_nxt, pick_ptr, win_idx;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic            revoke, revoke_nxt;
  logic            win_vld, owner_req, others_req, tenure_hit;

  // The revoked owner sits out exactly the one arbitration made in REVOKED.
  assign mask     = (state == REVOKED) ? rev_oh : '0;
  assign pick_ptr = (MODE == MODE_RR) ? ptr : '0;

  mutex_pick #(.N(N)) u_pick (
    .req    (bus.Request),
    .mask   (mask),
    .ptr    (pick_ptr),
    .onehot (win_oh),
    .idx    (win_idx),
    .valid  (win_vld)
  );

  assign owner_req  = |(bus.Request & grant);
  assign others_req = |(bus.Request & ~grant);
  assign tenure_hit = (MAX_HOLD > 0) && (hold_cnt == HW'(MAX_HOLD)) && others_req;

  // State register and registered outputs
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      grant    <= '0;
      idx      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      revoke   <= 1'b0;
      rev_oh   <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      idx      <= idx_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      revoke   <= revoke_nxt;
      rev_oh   <= rev_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      OWNED: begin
        if (!owner_req)      state_nxt = IDLE;
        else if (tenure_hit) state_nxt = REVOKED;
      end
      default: state_nxt = win_vld ? OWNED : IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping
  always_comb begin
    grant_nxt  = grant;
    idx_nxt    = idx;
    ptr_nxt    = ptr;
    hold_nxt   = hold_cnt;
    revoke_nxt = 1'b0;
    rev_nxt    = rev_oh;
    case (state)
      OWNED: begin
        if (!owner_req) begin
          grant_nxt = '0;
          idx_nxt   = '0;
        end else if (tenure_hit) begin
          grant_nxt  = '0;
          idx_nxt    = '0;
          revoke_nxt = 1'b1;
          rev_nxt    = grant;
        end else if (hold_cnt != HW'(MAX_HOLD)) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        if (win_vld) begin
          grant_nxt = win_oh;
          idx_nxt   = win_idx;
          hold_nxt  = '0;
          ptr_nxt   = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
        end else begin
          grant_nxt = '0;
          idx_nxt   = '0;
        end
      end
    endcase
  end

  assign bus.Grant      = grant;
  assign bus.GrantIndex = idx;
  assign bus.Busy       = |grant;
  assign bus.Revoke     = revoke;

endmodule

// File: tb/tb_mutex_arbiter.sv
// tb_mutex_arbiter: directed scenarios on four N=4 arbiters (fixed,
// round-robin, tenure 3, tenure 2) plus a random run on an N=5 round-robin
// arbiter with tenure 3, compared against an ownership-level reference model.
module tb_mutex_arbiter;

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 Clk = ~Clk;

  mutex_arbiter_if #(.N(4)) fix_if ();
  mutex_arbiter_if #(.N(4)) rr_if ();
  mutex_arbiter_if #(.N(4)) ten_if ();
  mutex_arbiter_if #(.N(4)) msk_if ();
  mutex_arbiter_if #(.N(5)) rnd_if ();

  mutex_arbiter #(.N(4), .MODE(0), .MAX_HOLD(0)) u_fix (.nReset(nReset), .Clk(Clk), .bus(fix_if));
  mutex_arbiter #(.N(4), .MODE(1), .MAX_HOLD(0)) u_rr  (.nReset(nReset), .Clk(Clk), .bus(rr_if));
  mutex_arbiter #(.N(4), .MODE(0), .MAX_HOLD(3)) u_ten (.nReset(nReset), .Clk(Clk), .bus(ten_if));
  mutex_arbiter #(.N(4), .MODE(0), .MAX_HOLD(2)) u_msk (.nReset(nReset), .Clk(Clk), .bus(msk_if));
  mutex_arbiter #(.N(5), .MODE(1), .MAX_HOLD(3)) u_rnd (.nReset(nReset), .Clk(Clk), .bus(rnd_if));

  // Reference model for the random run: who owns the resource, how long,
  // whose turn is next, and who is barred from the next arbitration.
  localparam int RN   = 5;
  localparam int RMAX = 3;
  int m_owner, m_cnt, m_masked, m_ptr;
  bit m_rev;

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic model_step(input logic [RN-1:0] r);
    logic [RN-1:0] rs;
    int cand, i;
    m_rev = 1'b0;
    if (m_owner >= 0) begin
      rs = r >> m_owner;
      if (!rs[0]) begin
        m_owner = -1;
      end else if (m_cnt == RMAX && (r & ~(5'b00001 << m_owner)) != 5'b0) begin
        m_masked = m_owner;
        m_owner  = -1;
        m_rev    = 1'b1;
      end else if (m_cnt < RMAX) begin
        m_cnt++;
      end
    end else begin
      cand = -1;
      for (int k = 0; k < RN; k++) begin
        i  = (m_ptr + k) % RN;
        rs = r >> i;
        if (cand < 0 && rs[0] && i != m_masked) cand = i;
      end
      m_masked = -1;
      if (cand >= 0) begin
        m_owner = cand;
        m_cnt   = 0;
        m_ptr   = (cand + 1) % RN;
      end
    end
  endtask

  task automatic test_reset;
    fix_if.Request = '0; rr_if.Request = '0; ten_if.Request = '0;
    msk_if.Request = '0; rnd_if.Request = '0;
    nReset = 1'b0;
    tick(2);
    n_checks++;
    if ({fix_if.Grant, fix_if.GrantIndex, fix_if.Busy, fix_if.Revoke} !== '0) begin
      n_fail++; $display("FAIL reset_fix: Grant=%b idx=%0d busy=%b rev=%b, required all 0",
                         fix_if.Grant, fix_if.GrantIndex, fix_if.Busy, fix_if.Revoke);
    end
    n_checks++;
    if ({rr_if.Grant, ten_if.Grant, msk_if.Grant, rnd_if.Grant, rnd_if.GrantIndex,
         rnd_if.Busy, rnd_if.Revoke, ten_if.Revoke} !== '0) begin
      n_fail++; $display("FAIL reset_all: rr=%b ten=%b msk=%b rnd=%b, required all 0",
                         rr_if.Grant, ten_if.Grant, msk_if.Grant, rnd_if.Grant);
    end
    nReset = 1'b1;
    tick(1);
  endtask

  task automatic test_fixed;
    fix_if.Request = 4'b1010;
    tick(1);
    n_checks++;
    if (fix_if.Grant !== 4'b0010 || fix_if.GrantIndex !== 2'd1 || fix_if.Busy !== 1'b1) begin
      n_fail++; $display("FAIL fixed_first: Grant=%b idx=%0d busy=%b, required 0010/1/1",
                         fix_if.Grant, fix_if.GrantIndex, fix_if.Busy);
    end
    tick(2);
    n_checks++;
    if (fix_if.Grant !== 4'b0010) begin
      n_fail++; $display("FAIL fixed_hold: Grant=%b, required 0010", fix_if.Grant);
    end
    fix_if.Request = 4'b1000;
    tick(1);
    n_checks++;
    if (fix_if.Grant !== 4'b0000 || fix_if.Busy !== 1'b0 || fix_if.GrantIndex !== 2'd0) begin
      n_fail++; $display("FAIL fixed_gap: Grant=%b busy=%b idx=%0d, required 0000/0/0",
                         fix_if.Grant, fix_if.Busy, fix_if.GrantIndex);
    end
    tick(1);
    n_checks++;
    if (fix_if.Grant !== 4'b1000 || fix_if.GrantIndex !== 2'd3) begin
      n_fail++; $display("FAIL fixed_second: Grant=%b idx=%0d, required 1000/3",
                         fix_if.Grant, fix_if.GrantIndex);
    end
    fix_if.Request = '0;
    tick(2);
  endtask

  task automatic test_round_robin;
    int e;
    rr_if.Request = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick(1);
      e = g % 4;
      n_checks++;
      if (rr_if.Grant !== (4'b0001 << e) || rr_if.GrantIndex !== 2'(e)) begin
        n_fail++; $display("FAIL rr_order[%0d]: Grant=%b idx=%0d, required idx %0d",
                           g, rr_if.Grant, rr_if.GrantIndex, e);
      end
      rr_if.Request = 4'b1111 & ~(4'b0001 << e);
      tick(1);
      n_checks++;
      if (rr_if.Grant !== 4'b0000) begin
        n_fail++; $display("FAIL rr_gap[%0d]: Grant=%b, required 0000", g, rr_if.Grant);
      end
      rr_if.Request = 4'b1111;
    end
    rr_if.Request = '0;
    tick(2);
  endtask

  task automatic test_tenure;
    ten_if.Request = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      tick(1);
      n_checks++;
      if (ten_if.Grant !== 4'b0001 || ten_if.Revoke !== 1'b0) begin
        n_fail++; $display("FAIL tenure_hold[%0d]: Grant=%b rev=%b, required 0001/0",
                           c, ten_if.Grant, ten_if.Revoke);
      end
      if (c == 2) ten_if.Request = 4'b0101;
    end
    tick(1);
    n_checks++;
    if (ten_if.Grant !== 4'b0000 || ten_if.Revoke !== 1'b1 || ten_if.Busy !== 1'b0) begin
      n_fail++; $display("FAIL tenure_revoke: Grant=%b rev=%b busy=%b, required 0000/1/0",
                         ten_if.Grant, ten_if.Revoke, ten_if.Busy);
    end
    tick(1);
    n_checks++;
    if (ten_if.Grant !== 4'b0100 || ten_if.GrantIndex !== 2'd2 || ten_if.Revoke !== 1'b0) begin
      n_fail++; $display("FAIL tenure_next: Grant=%b idx=%0d rev=%b, required 0100/2/0",
                         ten_if.Grant, ten_if.GrantIndex, ten_if.Revoke);
    end
    ten_if.Request = '0;
    tick(2);
  endtask

  task automatic test_uncontended;
    ten_if.Request = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      n_checks++;
      if (ten_if.Grant !== 4'b0001 || ten_if.Revoke !== 1'b0) begin
        n_fail++; $display("FAIL uncontended[%0d]: Grant=%b rev=%b, required 0001/0",
                           c, ten_if.Grant, ten_if.Revoke);
      end
    end
    ten_if.Request = '0;
    tick(2);
  endtask

  task automatic test_mask_after_revoke;
    logic [3:0] eg [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000,
                           4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    logic       er [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    msk_if.Request = 4'b0011;
    for (int c = 0; c < 9; c++) begin
      tick(1);
      n_checks++;
      if (msk_if.Grant !== eg[c] || msk_if.Revoke !== er[c]) begin
        n_fail++; $display("FAIL mask_seq[%0d]: Grant=%b rev=%b, required %b/%b",
                           c, msk_if.Grant, msk_if.Revoke, eg[c], er[c]);
      end
    end
    msk_if.Request = '0;
    tick(2);
  endtask

  task automatic test_reset_mid;
    rr_if.Request = 4'b0100;
    tick(1);
    n_checks++;
    if (rr_if.Grant !== 4'b0100) begin
      n_fail++; $display("FAIL rstmid_setup: Grant=%b, required 0100", rr_if.Grant);
    end
    nReset = 1'b0;
    #1;
    n_checks++;
    if (rr_if.Grant !== 4'b0000 || rr_if.Busy !== 1'b0 || rr_if.Revoke !== 1'b0 ||
        rr_if.GrantIndex !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_async: Grant=%b busy=%b rev=%b idx=%0d, required 0",
                         rr_if.Grant, rr_if.Busy, rr_if.Revoke, rr_if.GrantIndex);
    end
    rr_if.Request = 4'b1111;
    @(posedge Clk);
    #1;
    nReset = 1'b1;
    tick(1);
    n_checks++;
    if (rr_if.Grant !== 4'b0001 || rr_if.GrantIndex !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_ptr: Grant=%b idx=%0d, required 0001/0",
                         rr_if.Grant, rr_if.GrantIndex);
    end
    rr_if.Request = '0;
    tick(2);
  endtask

  task automatic test_random;
    logic [RN-1:0] r;
    logic [RN-1:0] exp_g;
    int            exp_i;
    r = '0;
    m_owner = -1; m_cnt = 0; m_masked = -1; m_ptr = 0; m_rev = 1'b0;
    for (int t = 0; t < 400; t++) begin
      for (int b = 0; b < RN; b++)
        if ($urandom_range(5) == 0) r = r ^ (5'b00001 << b);
      rnd_if.Request = r;
      model_step(r);
      tick(1);
      exp_g = (m_owner >= 0) ? (5'b00001 << m_owner) : 5'b0;
      exp_i = (m_owner >= 0) ? m_owner : 0;
      n_checks++;
      if (rnd_if.Grant !== exp_g || rnd_if.GrantIndex !== 3'(exp_i) ||
          rnd_if.Busy !== (m_owner >= 0) || rnd_if.Revoke !== m_rev) begin
        n_fail++; $display("FAIL random[%0d]: req=%b Grant=%b idx=%0d rev=%b, required %b/%0d/%b",
                           t, r, rnd_if.Grant, rnd_if.GrantIndex, rnd_if.Revoke,
                           exp_g, exp_i, m_rev);
      end
    end
    rnd_if.Request = '0;
    tick(2);
  endtask

  initial begin
    #1;
    test_reset;
    test_fixed;
    test_round_robin;
    test_tenure;
    test_uncontended;
    test_mask_after_revoke;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mutex_arbiter.md
# mutex_arbiter

Parametrised successor to the team's two-port fixed-priority mutex: grants exclusive ownership of one shared resource to one of N requesters. Adds a selectable round-robin mode, an encoded grant index, and an optional maximum-tenure limit that forcibly revokes a long-held grant when others are waiting. It sits between bus masters (DMA engines, CPU ports, test controllers) and a single shared slave or memory port.

## Interface
- N, 4, number of requesters (2..32)
- MODE, 0, 0 = fixed priority (index 0 highest), 1 = round-robin
- MAX_HOLD, 0, maximum consecutive Grant cycles while another request is pending; 0 = unlimited
- nReset  in  1  asynchronous, active-low reset
- Clk  in  1  clock, rising edge
- Request  in  N  level request per requester; held high for the whole ownership
- Grant  out  N  one-hot or zero; registered
- GrantIndex  out  max(1,$clog2(N))  index of the set Grant bit; 0 when Grant is zero
- Busy  out  1  Grant is nonzero
- Revoke  out  1  one-cycle pulse: the grant was removed by the tenure limit

## Operation
- States: IDLE (Grant = 0), OWNED (one Grant bit set), REVOKED (one-cycle forced gap after timeout).
- IDLE: if Request nonzero, pick a winner and go to OWNED; else stay.
- Fixed mode: the winner is the lowest set index.
- Round-robin mode: priority starts at ptr and wraps modulo N. On every grant to i, ptr becomes (i+1) mod N. ptr resets to 0.
- OWNED, owner's Request still high: hold Grant and increment hold_cnt.
- OWNED, owner's Request low: clear Grant, go to IDLE. This gives break-before-make: there is always at least one all-zero cycle between owners.
- Tenure limit (MAX_HOLD>0):
  - hold_cnt counts Grant cycles, saturating; it is cleared on entering OWNED.
  - When hold_cnt == MAX_HOLD and another requester's bit is set: clear Grant, pulse Revoke, go to REVOKED.
  - If no other request is pending, the owner keeps the grant indefinitely. The check is made every cycle.
- REVOKED: Grant = 0. In the next arbitration the revoked index is masked out, in both modes, and only for that one arbitration. Then go to IDLE logic that same cycle, i.e. REVOKED arbitrates with the mask.
- Requests of non-owners never affect Grant while OWNED, except through the tenure limit.
- Request bits changing in the same cycle as a release are sampled normally in the following IDLE cycle.

## Timing
- Reset values: Grant = 0, GrantIndex = 0, Busy = 0, Revoke = 0, state IDLE, ptr = 0, hold_cnt = 0.
- All outputs are registered; there is no combinational path from Request to any output.
- Grant latency: Request sampled high in IDLE at edge k gives Grant at edge k+1.
- Release latency: owner's Request low at edge k gives Grant = 0 after edge k+1. The earliest next grant is after edge k+2.
- Revoke: asserted in the same cycle Grant first reads 0. The next owner is granted after the following edge.
- hold_cnt width is $clog2(MAX_HOLD+1). Grant is at most MAX_HOLD+1 cycles wide when contended.
- Reset asserted mid-ownership clears all outputs immediately (asynchronously). After deassertion, arbitration restarts from ptr = 0.

## Structure
- Shared package mutex_pkg holds:
  - the state enum (IDLE, OWNED, REVOKED)
  - the MODE constants MODE_FIXED = 0 and MODE_RR = 1
  - an index-width function idx_w(N)
- Sub-module mutex_pick: combinational rotate-and-priority-encode.
  - Inputs: request vector, mask, start pointer.
  - Outputs: one-hot winner, index, valid.
  - Used by both modes (fixed mode uses a pointer tied to 0).

## Test plan
- Fixed, N=4: Request = 4'b1010 from IDLE, then hold.
  - Expected: Grant = 4'b0010 one cycle later, GrantIndex = 1.
  - Drop Request[1]: Grant = 0 for one cycle, then 4'b1000, GrantIndex = 3.
- Round-robin, N=4: all four requesters toggle their Request low for one cycle after each grant, then reassert.
  - Expected grant order: 0, 1, 2, 3, 0, with a one-cycle gap between each.
- Tenure, MAX_HOLD=3: Request[0] held high; Request[2] rises two cycles after Grant[0].
  - Expected: Grant[0] lasts 4 cycles, then Grant = 0 with Revoke = 1 for one cycle, then Grant = 4'b0100.
- Tenure uncontended, MAX_HOLD=3: only Request[0] held for 20 cycles.
  - Expected: Grant[0] stays high for the whole period and Revoke never pulses.
- Mask after revoke, fixed mode: Request[0] and Request[1] both held; MAX_HOLD=2.
  - Expected sequence: 0, revoke, 1 (index 0 masked), then after 1 is revoked, 0 again.
- Reset mid-ownership: nReset pulled low while Grant = 4'b0100.
  - Expected: Grant, Busy and Revoke are 0 immediately. After release, Request = 4'b1111 in round-robin mode grants index 0.
